// File: rtl/microsequencer_stack_if.sv
// -----------------------------------------------------------------------------
// microsequencer_stack_if
//
// Purpose
//   Bundles the per-cycle control fields and status outputs of the micro-PC
//   sequencer into one interface.
//
// Modports
//   master : the side that supplies the control fields and the decoder family
//            lines, and observes upc/sp/error status.
//   slave  : the sequencer itself.
//
// Signals
//   stall          1 = sequencer holds all of its state this cycle
//   family_bits    one-hot family lines from the instruction decoder
//   cs_j           jump target field of the current microinstruction
//   cs_cond        condition select (0 = unconditional)
//   cs_dec         dispatch on the instruction family
//   cs_call        push the return address, then jump
//   cs_ret         pop a return address
//   cond_in        branch-condition values ([2]=L, [1]=P, [0]=A)
//   upc            current micro-address
//   sp             number of valid return-stack entries
//   err_overflow   sticky: call issued with the stack full
//   err_underflow  sticky: return issued with the stack empty
//   err_nofamily   sticky: dispatch issued with no family line set
// -----------------------------------------------------------------------------
interface microsequencer_stack_if #(
  parameter int ADDR_W      = 7,
  parameter int FAMILY_W    = 16,
  parameter int NCOND       = 3,
  parameter int STACK_DEPTH = 4
) ();

  localparam int CSEL_W = $clog2(NCOND + 1);
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);

  logic                stall;
  logic [FAMILY_W-1:0] family_bits;
  logic [ADDR_W-1:0]   cs_j;
  logic [CSEL_W-1:0]   cs_cond;
  logic                cs_dec;
  logic                cs_call;
  logic                cs_ret;
  logic [NCOND-1:0]    cond_in;

  logic [ADDR_W-1:0]   upc;
  logic [SP_W-1:0]     sp;
  logic                err_overflow;
  logic                err_underflow;
  logic                err_nofamily;

  modport master (
    output stall, family_bits, cs_j, cs_cond, cs_dec, cs_call, cs_ret, cond_in,
    input  upc, sp, err_overflow, err_underflow, err_nofamily
  );

  modport slave (
    input  stall, family_bits, cs_j, cs_cond, cs_dec, cs_call, cs_ret, cond_in,
    output upc, sp, err_overflow, err_underflow, err_nofamily
  );

endinterface : microsequencer_stack_if

// File: rtl/microsequencer_stack.sv
// -----------------------------------------------------------------------------
// microsequencer_stack
//
// Purpose
//   Micro-PC sequencer for the ARMv4 control unit. Every cycle it selects the
//   next control-store address from one of four sources, in priority order:
//     1. return      : pop the hardware return stack (TRAP_ADDR on underflow)
//     2. dispatch    : jump to the decoded family's entry point
//                      (TRAP_ADDR when no family line is set)
//     3. call        : push upc+1, then take the jump target
//     4. jump        : take the jump target
//   The jump target is the cs_j field with one selected condition bit ORed in.
//   The control store itself is an external combinational ROM indexed by upc.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     microsequencer_stack_if.slave (control fields in, status out)
//
// Assumptions
//   NCOND <= ADDR_W so every condition bit lands inside the address.
//   STACK_DEPTH >= 1.
// -----------------------------------------------------------------------------
module microsequencer_stack #(
  parameter int                ADDR_W         = 7,
  parameter int                FAMILY_W       = 16,
  parameter int                DISPATCH_SHIFT = 3,
  parameter int                NCOND          = 3,
  parameter int                STACK_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR     = '0,
  parameter logic [ADDR_W-1:0] TRAP_ADDR      = '1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  microsequencer_stack_if.slave  bus
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int FAM_W = (FAMILY_W > 1) ? $clog2(FAMILY_W) : 1;
  // Wide enough that the dispatch shift never loses bits before truncation.
  localparam int DSP_W = ADDR_W + FAM_W + DISPATCH_SHIFT;

  typedef enum logic [1:0] {
    OP_JUMP,
    OP_CALL,
    OP_DEC,
    OP_RET
  } op_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] upc_q;
  logic [SP_W-1:0]   sp_q;
  logic              err_overflow_q;
  logic              err_underflow_q;
  logic              err_nofamily_q;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] upc_d;
  logic [SP_W-1:0]   sp_d;
  logic              push_en;
  logic              set_overflow;
  logic              set_underflow;
  logic              set_nofamily;

  op_e               op;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] dispatch_target;
  logic [DSP_W-1:0]  dispatch_wide;
  logic [FAM_W-1:0]  family_num;
  logic              family_found;
  logic [ADDR_W-1:0] return_addr;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;
  logic              stack_full;
  logic              stack_empty;

  // ---------------------------------------------------------------------------
  // Jump target: cs_cond==k ORs cond_in[k-1] into address bit k-1.
  // cs_cond==0 (or any value above NCOND) matches no k and leaves cs_j alone.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves it unassigned would infer a latch.
    jump_target = bus.cs_j;
    for (int k = 1; k <= NCOND; k++) begin
      if ((int'(bus.cs_cond) == k) && bus.cond_in[k-1]) begin
        jump_target[k-1] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Family dispatch: ascending scan so the highest set line wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    family_num = '0;
    for (int i = 0; i < FAMILY_W; i++) begin
      if (bus.family_bits[i]) begin
        family_num = FAM_W'(i);
      end
    end
  end

  assign family_found    = |bus.family_bits;
  assign dispatch_wide   = DSP_W'(family_num) << DISPATCH_SHIFT;
  assign dispatch_target = dispatch_wide[ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // Operation select. Lower-priority strobes asserted alongside a higher one
  // are dropped entirely, including their stack side effects.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (bus.cs_ret) begin
      op = OP_RET;
    end else if (bus.cs_dec) begin
      op = OP_DEC;
    end else if (bus.cs_call) begin
      op = OP_CALL;
    end else begin
      op = OP_JUMP;
    end
  end

  // ---------------------------------------------------------------------------
  // Return stack addressing. sp counts valid entries, so the top lives at
  // sp-1 and the next free slot at sp. Both indices are only used when the
  // corresponding empty/full guard allows it.
  // ---------------------------------------------------------------------------
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign top_idx     = IDX_W'(sp_q - SP_W'(1));
  assign push_idx    = IDX_W'(sp_q);
  // Wraps naturally at 2^ADDR_W - 1.
  assign return_addr = upc_q + ADDR_W'(1);

  // ---------------------------------------------------------------------------
  // Next-address and stack-pointer logic
  // ---------------------------------------------------------------------------
  always_comb begin
    upc_d         = upc_q;
    sp_d          = sp_q;
    push_en       = 1'b0;
    set_overflow  = 1'b0;
    set_underflow = 1'b0;
    set_nofamily  = 1'b0;

    if (!bus.stall) begin
      unique case (op)
        OP_RET: begin
          if (stack_empty) begin
            upc_d         = TRAP_ADDR;
            set_underflow = 1'b1;
          end else begin
            upc_d = stack_mem[top_idx];
            sp_d  = sp_q - SP_W'(1);
          end
        end

        OP_DEC: begin
          if (family_found) begin
            upc_d = dispatch_target;
          end else begin
            upc_d        = TRAP_ADDR;
            set_nofamily = 1'b1;
          end
        end

        OP_CALL: begin
          // The jump is taken even when the push has to be refused.
          upc_d = jump_target;
          if (stack_full) begin
            set_overflow = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
          end
        end

        default: begin
          upc_d = jump_target;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control state. Error flags are sticky until reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q           <= RESET_ADDR;
      sp_q            <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_nofamily_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      upc_q           <= upc_d;
      sp_q            <= sp_d;
      err_overflow_q  <= err_overflow_q  | set_overflow;
      err_underflow_q <= err_underflow_q | set_underflow;
      err_nofamily_q  <= err_nofamily_q  | set_nofamily;
    end
  end

  // ---------------------------------------------------------------------------
  // Return-stack storage
  // ---------------------------------------------------------------------------
  // NOTE: the stack array has no reset; clearing sp already makes every entry
  // invalid, and an unreset array maps onto plain storage cells.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= return_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.upc           = upc_q;
  assign bus.sp            = sp_q;
  assign bus.err_overflow  = err_overflow_q;
  assign bus.err_underflow = err_underflow_q;
  assign bus.err_nofamily  = err_nofamily_q;

endmodule : microsequencer_stack

// File: tb/tb_microsequencer_stack.sv
// -----------------------------------------------------------------------------
// tb_microsequencer_stack
//
// Directed bench for microsequencer_stack at default parameters. Each task
// covers one feature, drives its own vectors and compares against
// hand-computed constants. Inputs change at posedge+1 or on the negedge;
// outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_microsequencer_stack;

  localparam int ADDR_W      = 7;
  localparam int FAMILY_W    = 16;
  localparam int NCOND       = 3;
  localparam int STACK_DEPTH = 4;
  localparam int SP_W        = 3;
  localparam int CSEL_W      = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  microsequencer_stack_if #(
    .ADDR_W      (ADDR_W),
    .FAMILY_W    (FAMILY_W),
    .NCOND       (NCOND),
    .STACK_DEPTH (STACK_DEPTH)
  ) bus ();

  microsequencer_stack #(
    .ADDR_W         (ADDR_W),
    .FAMILY_W       (FAMILY_W),
    .DISPATCH_SHIFT (3),
    .NCOND          (NCOND),
    .STACK_DEPTH    (STACK_DEPTH),
    .RESET_ADDR     (7'd0),
    .TRAP_ADDR      (7'd127)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic idle();
    bus.stall       = 1'b0;
    bus.family_bits = '0;
    bus.cs_j        = '0;
    bus.cs_cond     = '0;
    bus.cs_dec      = 1'b0;
    bus.cs_call     = 1'b0;
    bus.cs_ret      = 1'b0;
    bus.cond_in     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one microinstruction for one clock, then sample.
  task automatic cycle(input logic [ADDR_W-1:0]   j,
                       input logic [CSEL_W-1:0]   cond,
                       input logic [NCOND-1:0]    cin,
                       input logic [FAMILY_W-1:0] fam,
                       input logic                dec,
                       input logic                call,
                       input logic                ret);
    bus.cs_j        = j;
    bus.cs_cond     = cond;
    bus.cond_in     = cin;
    bus.family_bits = fam;
    bus.cs_dec      = dec;
    bus.cs_call     = call;
    bus.cs_ret      = ret;
    tick();
  endtask

  task automatic apply_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle();
    bus.cs_j = 7'd5;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.upc !== 7'd0) begin
      errors++; $display("FAIL reset_upc: got %0d want 0", bus.upc);
    end
    checks++;
    if (bus.sp !== 3'd0) begin
      errors++; $display("FAIL reset_sp: got %0d want 0", bus.sp);
    end
    checks++;
    if ({bus.err_overflow, bus.err_underflow, bus.err_nofamily} !== 3'b000) begin
      errors++; $display("FAIL reset_errs: got %b want 000",
                         {bus.err_overflow, bus.err_underflow, bus.err_nofamily});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.upc !== 7'd5) begin
      errors++; $display("FAIL first_jump: got %0d want 5", bus.upc);
    end
    checks++;
    if ({bus.sp, bus.err_overflow, bus.err_underflow, bus.err_nofamily} !== 6'd0) begin
      errors++; $display("FAIL first_jump_status: sp=%0d errs=%b want 0/000", bus.sp,
                         {bus.err_overflow, bus.err_underflow, bus.err_nofamily});
    end
  endtask

  task automatic test_cond_jump();
    logic [ADDR_W-1:0] j_v   [6] = '{7'd8, 7'd8, 7'd8,   7'd8,   7'd8,   7'd64};
    logic [CSEL_W-1:0] sel_v [6] = '{2'd2, 2'd2, 2'd3,   2'd1,   2'd0,   2'd1};
    logic [NCOND-1:0]  cin_v [6] = '{3'b010, 3'b000, 3'b100, 3'b110, 3'b111, 3'b001};
    logic [ADDR_W-1:0] exp_v [6] = '{7'd10, 7'd8, 7'd12,  7'd8,   7'd8,   7'd65};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(j_v[i], sel_v[i], cin_v[i], '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.upc !== exp_v[i]) begin
        errors++; $display("FAIL cond_jump[%0d]: got %0d want %0d", i, bus.upc, exp_v[i]);
      end
    end
  endtask

  task automatic test_dispatch();
    logic [FAMILY_W-1:0] fam_v [4] = '{16'h0024, 16'h8000, 16'h0001, 16'h0003};
    logic [ADDR_W-1:0]   exp_v [4] = '{7'd40,    7'd120,   7'd0,     7'd8};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      // cs_j is nonzero so a dispatch that fell through to the jump shows up.
      cycle(7'd99, '0, '0, fam_v[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.upc !== exp_v[i]) begin
        errors++; $display("FAIL dispatch[%0d]: got %0d want %0d", i, bus.upc, exp_v[i]);
      end
    end
    checks++;
    if (bus.err_nofamily !== 1'b0) begin
      errors++; $display("FAIL nofamily_early: got %b want 0", bus.err_nofamily);
    end
    cycle(7'd99, '0, '0, 16'h0000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.upc !== 7'd127) begin
      errors++; $display("FAIL nofamily_trap: got %0d want 127", bus.upc);
    end
    checks++;
    if ({bus.err_overflow, bus.err_underflow, bus.err_nofamily} !== 3'b001) begin
      errors++; $display("FAIL nofamily_flag: got %b want 001",
                         {bus.err_overflow, bus.err_underflow, bus.err_nofamily});
    end
    cycle(7'd5, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.upc, bus.err_nofamily} !== {7'd5, 1'b1}) begin
      errors++; $display("FAIL nofamily_sticky: upc=%0d flag=%b want 5/1", bus.upc, bus.err_nofamily);
    end
  endtask

  task automatic test_call_ret();
    apply_reset();
    cycle(7'd12, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle(7'd60, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.upc, bus.sp} !== {7'd60, 3'd1}) begin
      errors++; $display("FAIL call: upc=%0d sp=%0d want 60/1", bus.upc, bus.sp);
    end
    cycle(7'd33, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus.upc, bus.sp} !== {7'd13, 3'd0}) begin
      errors++; $display("FAIL ret: upc=%0d sp=%0d want 13/0", bus.upc, bus.sp);
    end
    cycle(7'd33, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus.upc, bus.sp, bus.err_underflow} !== {7'd127, 3'd0, 1'b1}) begin
      errors++; $display("FAIL underflow: upc=%0d sp=%0d flag=%b want 127/0/1",
                         bus.upc, bus.sp, bus.err_underflow);
    end
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] ret_v [4] = '{7'd31, 7'd21, 7'd11, 7'd1};
    logic [SP_W-1:0]   exp_sp;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(ADDR_W'(10 * (i + 1)), '0, '0, '0, 1'b0, 1'b1, 1'b0);
      exp_sp = (i < 4) ? SP_W'(i + 1) : SP_W'(4);
      checks++;
      if ({bus.upc, bus.sp, bus.err_overflow} !== {ADDR_W'(10 * (i + 1)), exp_sp, (i == 4)}) begin
        errors++; $display("FAIL nested_call[%0d]: upc=%0d sp=%0d ovf=%b want %0d/%0d/%0d",
                           i, bus.upc, bus.sp, bus.err_overflow, 10 * (i + 1), exp_sp, (i == 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle('0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({bus.upc, bus.sp} !== {ret_v[i], SP_W'(3 - i)}) begin
        errors++; $display("FAIL unwind[%0d]: upc=%0d sp=%0d want %0d/%0d",
                           i, bus.upc, bus.sp, ret_v[i], 3 - i);
      end
    end
    checks++;
    if ({bus.err_overflow, bus.err_underflow, bus.err_nofamily} !== 3'b100) begin
      errors++; $display("FAIL overflow_sticky: got %b want 100",
                         {bus.err_overflow, bus.err_underflow, bus.err_nofamily});
    end
  endtask

  task automatic test_priority_wrap();
    apply_reset();
    cycle(7'd12, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle(7'd60, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    // ret + call: pop only.
    cycle(7'd70, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({bus.upc, bus.sp} !== {7'd13, 3'd0}) begin
      errors++; $display("FAIL ret_over_call: upc=%0d sp=%0d want 13/0", bus.upc, bus.sp);
    end
    // dec + call: dispatch only, no push.
    cycle(7'd70, '0, '0, 16'h0004, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({bus.upc, bus.sp} !== {7'd16, 3'd0}) begin
      errors++; $display("FAIL dec_over_call: upc=%0d sp=%0d want 16/0", bus.upc, bus.sp);
    end
    // dec + ret on an empty stack: underflow, not nofamily.
    cycle(7'd70, '0, '0, 16'h0000, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({bus.upc, bus.err_underflow, bus.err_nofamily} !== {7'd127, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ret_over_dec: upc=%0d unf=%b nof=%b want 127/1/0",
                         bus.upc, bus.err_underflow, bus.err_nofamily);
    end
    // Call from upc=127 pushes the wrapped return address 0.
    cycle(7'd3, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.upc, bus.sp} !== {7'd3, 3'd1}) begin
      errors++; $display("FAIL wrap_call: upc=%0d sp=%0d want 3/1", bus.upc, bus.sp);
    end
    cycle(7'd50, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus.upc, bus.sp} !== {7'd0, 3'd0}) begin
      errors++; $display("FAIL wrap_ret: upc=%0d sp=%0d want 0/0", bus.upc, bus.sp);
    end
  endtask

  task automatic test_stall_reset();
    apply_reset();
    cycle('0, '0, '0, '0, 1'b0, 1'b0, 1'b1);      // underflow -> 127
    cycle(7'd12, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle(7'd60, '0, '0, '0, 1'b0, 1'b1, 1'b0);   // upc 60, sp 1
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(7'd99, 2'd1, 3'b111, '0, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({bus.upc, bus.sp, bus.err_overflow, bus.err_underflow} !== {7'd60, 3'd1, 1'b0, 1'b1}) begin
        errors++; $display("FAIL stall_hold[%0d]: upc=%0d sp=%0d ovf=%b unf=%b want 60/1/0/1",
                           i, bus.upc, bus.sp, bus.err_overflow, bus.err_underflow);
      end
    end
    // Asynchronous reset mid-cycle, well away from any clock edge.
    bus.stall = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.upc, bus.sp, bus.err_overflow, bus.err_underflow, bus.err_nofamily} !== 13'd0) begin
      errors++; $display("FAIL async_reset: upc=%0d sp=%0d errs=%b want 0/0/000", bus.upc, bus.sp,
                         {bus.err_overflow, bus.err_underflow, bus.err_nofamily});
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(7'd5, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.upc, bus.sp} !== {7'd5, 3'd0}) begin
      errors++; $display("FAIL post_reset: upc=%0d sp=%0d want 5/0", bus.upc, bus.sp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b1;
    idle();
    test_reset();
    test_cond_jump();
    test_dispatch();
    test_call_ret();
    test_overflow();
    test_priority_wrap();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_microsequencer_stack
